jk_cmd_sequencer: RTL and testbench

Upstream command stage for jk_flip_flop. It accepts set/reset/toggle/hold commands over a valid/ready interface and buffers them in a small FIFO. Each command drives J/K for a programmed number of CLK cycles, with registered outputs that connect directly to the flip-flop's J and K inputs. It also keeps a reference model of the flip-flop's Q for self-checking and status.

---
 rtl/jk_cmd_sequencer.sv | 150 +++++++++++++++
 tb/tb_jk_cmd_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/jk_cmd_sequencer.sv
// Command sequencer feeding a jk_flip_flop: buffers HOLD/SET/RESET/TOGGLE commands
// in a FIFO and drives registered J/K for each command's duration.
module jk_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int DUR_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [DUR_W-1:0] cmd_dur,
  output logic             J,
  output logic             K,
  output logic             q_model,
  output logic             done,
  output logic             busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_APPLY = 1'b1
  } state_e;

  typedef struct packed {
    logic [1:0]       op;
    logic [DUR_W-1:0] dur;
  } cmd_t;

  cmd_t             mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  state_e           state_q, state_d;
  logic [DUR_W-1:0] cnt_q, cnt_d;
  logic             j_q, j_d;
  logic             k_q, k_d;
  logic             q_q, q_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             push;
  logic             pop;
  logic             fifo_empty;
  cmd_t             head;
  logic [DUR_W-1:0] head_len;

  // Handshake: a command transfers on a posedge where cmd_valid && cmd_ready;
  // the producer holds op/dur stable until then. cmd_ready uses the pre-edge count.
  assign fifo_empty = (count_q == '0);
  assign cmd_ready  = !RST && (count_q != CW'(DEPTH));
  assign push       = cmd_valid && cmd_ready;
  assign head       = mem_q[rptr_q];
  assign head_len   = (head.dur == '0) ? DUR_W'(1) : head.dur;
  assign pop        = !fifo_empty && ((state_q == S_IDLE) || (cnt_q == DUR_W'(1)));

  // Op encoding maps straight onto J/K: op[0] drives J, op[1] drives K.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    j_d     = j_q;
    k_d     = k_q;
    if (pop) begin
      state_d = S_APPLY;
      cnt_d   = head_len;
      j_d     = head.op[0];
      k_d     = head.op[1];
    end else if (state_q == S_APPLY) begin
      if (cnt_q > DUR_W'(1)) begin
        cnt_d = cnt_q - DUR_W'(1);
      end else begin
        state_d = S_IDLE;
        j_d     = 1'b0;
        k_d     = 1'b0;
      end
    end else begin
      j_d = 1'b0;
      k_d = 1'b0;
    end
  end

  always_comb begin
    wptr_d  = push ? (wptr_q + AW'(1)) : wptr_q;
    rptr_d  = pop  ? (rptr_q + AW'(1)) : rptr_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Mirror of the downstream flip-flop, one edge behind J/K.
  always_comb begin
    q_d = q_q;
    case ({j_q, k_q})
      2'b10:   q_d = 1'b1;
      2'b01:   q_d = 1'b0;
      2'b11:   q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  always_comb begin
    done_d = (state_d == S_APPLY) && (cnt_d == DUR_W'(1));
    busy_d = (state_d == S_APPLY) || (count_d != '0);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
      q_q     <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      j_q     <= j_d;
      k_q     <= k_d;
      q_q     <= q_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wptr_q] <= {cmd_op, cmd_dur};
    end
  end

  assign J       = j_q;
  assign K       = k_q;
  assign q_model = q_q;
  assign done    = done_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Bench for jk_cmd_sequencer: each accepted command becomes an expected apply window
// in a queue; a negedge monitor checks J/K/done/busy/cmd_ready/q_model every cycle.
module tb_jk_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int DUR_W = 8;
  localparam int W     = 44;  // {start[31:0], len[8:0], j, k, q_after}

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_RESET  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd_op = 2'b00;
  logic [DUR_W-1:0] cmd_dur = '0;
  logic             cmd_ready, J, K, q_model, done, busy;

  int         n_tests = 0;
  int         n_fail = 0;
  int         cyc = 0;
  bit         mon_en = 1'b0;
  logic [W-1:0] exp_q[$];

  // driver-side reference state
  int   next_free = 0;
  logic model_q = 1'b0;

  // monitor-side state
  logic         q_known = 1'b0;
  bit           prev_mid = 1'b0;
  int           m_fifo_cnt, m_start, m_len;
  logic         m_active, m_j, m_k, m_done;
  logic [W-1:0] m_head;

  jk_cmd_sequencer #(.DEPTH(DEPTH), .DUR_W(DUR_W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_dur   (cmd_dur),
    .J         (J),
    .K         (K),
    .q_model   (q_model),
    .done      (done),
    .busy      (busy)
  );

  // clock / cycle counter
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk_rec(input int start, input int len,
                                          input logic j, input logic k, input logic q);
    logic [8:0] l9;
    l9 = len[8:0];
    return {start, l9, j, k, q};
  endfunction

  // scoreboard monitor
  always @(negedge CLK) begin
    if (mon_en) begin
      m_fifo_cnt = 0;
      foreach (exp_q[i]) if (int'(exp_q[i][43:12]) > cyc) m_fifo_cnt++;
      m_active = 1'b0;
      m_j = 1'b0;
      m_k = 1'b0;
      m_done = 1'b0;
      if (exp_q.size() != 0) begin
        m_head  = exp_q[0];
        m_start = int'(m_head[43:12]);
        m_len   = int'(m_head[11:3]);
        if (m_start <= cyc) begin
          m_active = 1'b1;
          m_j      = m_head[2];
          m_k      = m_head[1];
          m_done   = (cyc == m_start + m_len - 1);
        end
      end
      chk("J", J, m_j);
      chk("K", K, m_k);
      chk("done", done, m_done);
      chk("busy", busy, exp_q.size() != 0);
      chk("cmd_ready", cmd_ready, !RST && (m_fifo_cnt < DEPTH));
      if (!prev_mid) chk("q_model", q_model, q_known);
      prev_mid = m_active && !m_done;
      if (m_done) begin
        q_known = m_head[0];
        void'(exp_q.pop_front());
      end
      if (RST) begin
        exp_q.delete();
        q_known  = 1'b0;
        prev_mid = 1'b0;
      end
    end
  end

  // driver tasks: all return at posedge + #1
  task automatic send(input logic [1:0] op, input int dur);
    int   t, len, start;
    bit   rdy, acc;
    logic j, k;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_dur   = dur[DUR_W-1:0];
    acc       = 1'b0;
    for (int w = 0; w < 200 && !acc; w++) begin
      @(negedge CLK);
      rdy = cmd_ready;
      @(posedge CLK);
      #1;
      if (rdy) acc = 1'b1;
    end
    cmd_valid = 1'b0;
    chk("send_accept", acc, 1);
    if (acc) begin
      t     = cyc;
      len   = (dur == 0) ? 1 : dur;
      start = (t + 1 > next_free) ? t + 1 : next_free;
      next_free = start + len;
      j = 1'b0;
      k = 1'b0;
      case (op)
        OP_SET:    begin j = 1'b1; model_q = 1'b1; end
        OP_RESET:  begin k = 1'b1; model_q = 1'b0; end
        OP_TOGGLE: begin j = 1'b1; k = 1'b1; if (len % 2 == 1) model_q = ~model_q; end
        default:   ;
      endcase
      exp_q.push_back(mk_rec(start, len, j, k, model_q));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) begin
      @(posedge CLK);
      #1;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST       = 1'b0;
    next_free = 0;
    model_q   = 1'b0;
  endtask

  initial begin
    @(posedge CLK);
    #1;
    mon_en = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    idle(2);

    send(OP_SET, 3);
    wait_drain();
    idle(2);
    send(OP_TOGGLE, 4);
    wait_drain();
    send(OP_TOGGLE, 5);
    wait_drain();
    idle(1);

    send(OP_HOLD, 10);
    send(OP_RESET, 2);
    send(OP_SET, 1);
    send(OP_HOLD, 3);
    send(OP_TOGGLE, 1);
    send(OP_SET, 2);
    wait_drain();

    send(OP_RESET, 0);
    wait_drain();

    send(OP_TOGGLE, 8);
    send(OP_SET, 2);
    send(OP_RESET, 3);
    idle(3);
    do_reset();
    idle(4);

    send(OP_SET, 1);
    wait_drain();
    send(OP_HOLD, 5);
    wait_drain();
    idle(2);

    for (int n = 0; n < 60; n++) begin
      logic [1:0] op;
      int dur;
      op  = 2'($urandom_range(0, 3));
      dur = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
      send(op, dur);
      idle(int'($urandom_range(0, 3)));
      if ($urandom_range(0, 24) == 0) do_reset();
    end
    wait_drain();
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
